// File: rtl/rv523_arb_pkg.sv
// Shared types and default widths for the RV523 memory-port arbiter.
// Optional busy timeout: define RV523_ARB_TIMEOUT_EN.
package rv523_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;
    localparam int TMO_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rv523_rr_pick.sv
// Combinational round-robin picker: first set request above ptr, with wrap.
module rv523_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx
);

    int   j;
    logic found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                win[j]  = 1'b1;
                win_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/rv523_mem_arbiter.sv
// Round-robin owner of the single RV523 memory port, one transaction at a time.
// Optional busy timeout: define RV523_ARB_TIMEOUT_EN.
module rv523_mem_arbiter
    import rv523_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TMO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               mem_valid,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_we,
    output logic [DW-1:0]      mem_wdata,
    input  logic               mem_ready,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1 || TMO_CYC >= 2**TMO_W) begin : g_bad_cfg
        $error("rv523_mem_arbiter: unsupported NREQ/TMO_CYC");
    end

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, owner, win_idx;
    logic [NREQ-1:0] win;
    logic            take, fin;

    rv523_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

`ifdef RV523_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] cnt;
    logic             tmo;
`endif

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        fin      = 1'b0;
`ifdef RV523_ARB_TIMEOUT_EN
        tmo      = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    take     = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A ready in the limit cycle completes normally.
                if (mem_ready) begin
                    fin      = 1'b1;
                    state_nx = ST_IDLE;
                end
`ifdef RV523_ARB_TIMEOUT_EN
                else if (cnt == TMO_W'(TMO_CYC)) begin
                    fin      = 1'b1;
                    tmo      = 1'b1;
                    state_nx = ST_IDLE;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    assign mem_valid = (state == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= PW'(NREQ - 1);
            owner     <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            gnt  <= take ? win : '0;
            done <= fin ? (NREQ'(1) << owner) : '0;
            if (take) begin
                owner     <= win_idx;
                mem_addr  <= req_addr[int'(win_idx)*AW +: AW];
                mem_we    <= req_we[win_idx];
                mem_wdata <= req_wdata[int'(win_idx)*DW +: DW];
            end
            if (fin) begin
                ptr <= owner;
`ifdef RV523_ARB_TIMEOUT_EN
                if (tmo)          rdata <= '0;
                else if (!mem_we) rdata <= mem_rdata;
`else
                if (!mem_we) rdata <= mem_rdata;
`endif
            end
        end
    end

`ifdef RV523_ARB_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= fin & tmo;
            if (take)                    cnt <= '0;
            else if (state == ST_BUSY)   cnt <= cnt + 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rv523_mem_arbiter.sv
// Directed self-checking bench for rv523_mem_arbiter (NREQ=4, TMO_CYC=10).
module tb_rv523_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic              mem_ready = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic [NREQ-1:0]   gnt, done;
    logic [DW-1:0]     rdata, mem_wdata;
    logic [AW-1:0]     mem_addr;
    logic              err, mem_valid, mem_we;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv523_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO_CYC(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] a,
                          input logic w, input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_we[i]             = w;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        mem_ready = 1'b1;
        repeat (3) step();
        checks++;
        if ({gnt, done, err, mem_valid} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=0", {gnt, done, err, mem_valid});
        end
        checks++;
        if ({rdata, mem_addr, mem_we, mem_wdata} !== 33'b0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {rdata, mem_addr, mem_we, mem_wdata});
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_gnt got=%b exp=0001", gnt);
        end
        checks++;
        if (mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_valid got=%b exp=1", mem_valid);
        end
        rst_n = 1'b0;
        req = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        int n;
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;
        exp_g[4] = 4'b0001;
        req = 4'b1111;
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            step();
            while (gnt == '0 && n < 6) begin
                step();
                n++;
            end
            checks++;
            if (gnt !== exp_g[k]) begin
                failures++;
                $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, exp_g[k]);
            end
            if (k == 4) req = '0;
            step();
            checks++;
            if (done !== exp_g[k]) begin
                failures++;
                $display("FAIL rr_done%0d got=%b exp=%b", k, done, exp_g[k]);
            end
        end
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_read_wait();
        int vcnt;
        set_ch(2, 16'h1234, 1'b0, 8'h00);
        mem_rdata = 8'h5C;
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100 || mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_gnt got=%b/%b exp=0100/1", gnt, mem_valid);
        end
        req = '0;
        set_ch(2, 16'hBEEF, 1'b1, 8'hEE);
        vcnt = 1;
        for (int i = 2; i <= 6; i++) begin
            step();
            if (mem_valid) vcnt++;
            if (i == 6) begin
                mem_ready = 1'b1;
                mem_rdata = 8'hA5;
            end
        end
        checks++;
        if (mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL rd_addr_hold got=%h/%b exp=1234/0", mem_addr, mem_we);
        end
        step();
        mem_ready = 1'b0;
        checks++;
        if (done !== 4'b0100) begin
            failures++;
            $display("FAIL rd_done got=%b exp=0100", done);
        end
        checks++;
        if (rdata !== 8'hA5 || err !== 1'b0) begin
            failures++;
            $display("FAIL rd_data got=%h/%b exp=a5/0", rdata, err);
        end
        checks++;
        if (vcnt != 6 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_valid_len got=%0d/%b exp=6/0", vcnt, mem_valid);
        end
    endtask

    task automatic test_write_hold();
        logic seen;
        set_ch(1, 16'h0042, 1'b1, 8'h5A);
        req = 4'b0010;
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL wr_gnt got=%b exp=0010", gnt);
        end
        req = 4'b1000;
        set_ch(1, 16'hFFFF, 1'b0, 8'h00);
        step();
        req = '0;
        checks++;
        if ({mem_addr, mem_we, mem_wdata} !== {16'h0042, 1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL wr_hold got=%h/%b/%h exp=0042/1/5a", mem_addr, mem_we, mem_wdata);
        end
        mem_ready = 1'b1;
        mem_rdata = 8'h33;
        step();
        mem_ready = 1'b0;
        checks++;
        if (done !== 4'b0010 || rdata !== 8'hA5) begin
            failures++;
            $display("FAIL wr_done got=%b/%h exp=0010/a5", done, rdata);
        end
        seen = 1'b0;
        repeat (3) begin
            step();
            seen = seen | (|gnt) | mem_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL wr_withdraw got=%b exp=0", seen);
        end
    endtask

`ifdef RV523_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int vcnt;
        int n;
        set_ch(2, 16'h0300, 1'b0, 8'h00);
        mem_rdata = 8'h99;
        req = 4'b0100;
        step();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL tmo_gnt got=%b exp=0100", gnt);
        end
        req = '0;
        vcnt = 1;
        n = 0;
        while (done == '0 && n < 30) begin
            step();
            if (mem_valid) vcnt++;
            n++;
        end
        checks++;
        if (done !== 4'b0100 || err !== 1'b1 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL tmo_done got=%b/%b/%h exp=0100/1/00", done, err, rdata);
        end
        checks++;
        if (vcnt != 11) begin
            failures++;
            $display("FAIL tmo_len got=%0d exp=11", vcnt);
        end
        set_ch(0, 16'h0400, 1'b0, 8'h00);
        req = 4'b0001;
        step();
        req = '0;
        repeat (10) step();
        checks++;
        if (mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL tmo_limit_valid got=%b exp=1", mem_valid);
        end
        mem_ready = 1'b1;
        mem_rdata = 8'h7E;
        step();
        mem_ready = 1'b0;
        checks++;
        if (done !== 4'b0001 || err !== 1'b0 || rdata !== 8'h7E) begin
            failures++;
            $display("FAIL tmo_ready_wins got=%b/%b/%h exp=0001/0/7e", done, err, rdata);
        end
        step();
    endtask
`endif

    task automatic test_async_reset();
        logic seen;
        set_ch(0, 16'h0777, 1'b0, 8'h00);
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL ar_gnt got=%b exp=0001", gnt);
        end
        req = '0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_valid_drop got=%b exp=0", mem_valid);
        end
        seen = 1'b0;
        repeat (2) begin
            step();
            seen = seen | (|done);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL ar_no_done got=%b exp=0", seen);
        end
        req = 4'b1111;
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL ar_restart got=%b exp=0001", gnt);
        end
        req = '0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read_wait();
        test_write_hold();
`ifdef RV523_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
